// File: rtl/srcnn_mul_pipe_acc.sv
// Pipelined multiplier with optional multiply-accumulate, valid/ready handshake on both sides
// and an overflow flag for results that do not fit the output width.
module srcnn_mul_pipe_acc #(
   parameter int unsigned DIN0_WIDTH = 14,
   parameter int unsigned DIN1_WIDTH = 12,
   parameter int unsigned DOUT_WIDTH = 26,
   parameter int unsigned NUM_STAGE  = 3,
   parameter int unsigned SIGNED0    = 0,
   parameter int unsigned SIGNED1    = 0,
   parameter int unsigned ACC_EN     = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  in_first,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  dout_ovf
);

   localparam int unsigned ExtW      = DIN0_WIDTH + DIN1_WIDTH + 1;
   localparam int unsigned MulW      = (ExtW > 64) ? ExtW : 64;
   localparam bit          ResSigned = (SIGNED0 != 0) || (SIGNED1 != 0);

   // True when v does not fit DOUT_WIDTH bits under the result signedness.
   function automatic logic ovf_of(input logic [63:0] v);
      logic signed [63:0] hi_s;
      hi_s = $signed(v) >>> (DOUT_WIDTH - 1);
      if (ResSigned) begin
         return (hi_s != '0) && (hi_s != '1);
      end
      return (v >> DOUT_WIDTH) != '0;
   endfunction

   // ------------------------------------------------------------------
   // Operand extension and product
   // ------------------------------------------------------------------
   logic [MulW-1:0] op0_ext, op1_ext, prod_full;
   logic [63:0]     prod_in;
   logic            unused_prod;

   always_comb begin
      if (SIGNED0 != 0) begin
         op0_ext = MulW'($signed(din0));
      end else begin
         op0_ext = MulW'(din0);
      end
      if (SIGNED1 != 0) begin
         op1_ext = MulW'($signed(din1));
      end else begin
         op1_ext = MulW'(din1);
      end
      // Low bits of an extended product are exact for any operand signedness mix.
      prod_full = op0_ext * op1_ext;
      prod_in   = prod_full[63:0];
   end

   assign unused_prod = ^prod_full;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic out_valid_q, out_valid_d;
   logic advance, accept;

   assign advance  = ~out_valid_q | out_ready;
   assign in_ready = advance & ap_rst_n;
   assign accept   = in_valid & in_ready;

   // ------------------------------------------------------------------
   // Intermediate stages feeding the final (output) stage
   // ------------------------------------------------------------------
   logic        pre_valid, pre_first, pre_last;
   logic [63:0] pre_prod;

   if (NUM_STAGE > 1) begin : g_pipe
      localparam int unsigned Depth = NUM_STAGE - 1;

      logic [Depth-1:0]       vld_q, vld_d;
      logic [Depth-1:0]       first_q, first_d;
      logic [Depth-1:0]       last_q, last_d;
      logic [Depth-1:0][63:0] prod_q, prod_d;

      always_comb begin
         vld_d   = vld_q;
         first_d = first_q;
         last_d  = last_q;
         prod_d  = prod_q;
         if (advance) begin
            vld_d[0]   = accept;
            first_d[0] = in_first;
            last_d[0]  = in_last;
            prod_d[0]  = prod_in;
            for (int i = 1; i < Depth; i++) begin
               vld_d[i]   = vld_q[i-1];
               first_d[i] = first_q[i-1];
               last_d[i]  = last_q[i-1];
               prod_d[i]  = prod_q[i-1];
            end
         end
      end

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            prod_q  <= '0;
         end else begin
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
            prod_q  <= prod_d;
         end
      end

      assign pre_valid = vld_q[Depth-1];
      assign pre_first = first_q[Depth-1];
      assign pre_last  = last_q[Depth-1];
      assign pre_prod  = prod_q[Depth-1];
   end else begin : g_direct
      assign pre_valid = accept;
      assign pre_first = in_first;
      assign pre_last  = in_last;
      assign pre_prod  = prod_in;
   end

   // ------------------------------------------------------------------
   // Final stage: output register and accumulator
   // ------------------------------------------------------------------
   logic [DOUT_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;
   logic [63:0]           acc_q, acc_d;
   logic                  acc_ovf_q, acc_ovf_d;
   logic                  first_flag_q, first_flag_d;
   logic                  is_first;
   logic [63:0]           sum;
   logic                  sum_ovf;

   always_comb begin
      out_valid_d  = out_valid_q;
      dout_d       = dout_q;
      ovf_d        = ovf_q;
      acc_d        = acc_q;
      acc_ovf_d    = acc_ovf_q;
      first_flag_d = first_flag_q;

      // A beat with no preceding in_first since reset still starts a fresh sum.
      is_first = pre_first | first_flag_q;
      sum      = is_first ? pre_prod : (acc_q + pre_prod);
      sum_ovf  = ovf_of(sum) | (~is_first & acc_ovf_q);

      if (advance) begin
         out_valid_d = 1'b0;
         if (pre_valid) begin
            first_flag_d = 1'b0;
            if (ACC_EN != 0) begin
               acc_d     = sum;
               acc_ovf_d = sum_ovf;
               if (pre_last) begin
                  out_valid_d = 1'b1;
                  dout_d      = sum[DOUT_WIDTH-1:0];
                  ovf_d       = sum_ovf;
               end
            end else begin
               out_valid_d = 1'b1;
               dout_d      = pre_prod[DOUT_WIDTH-1:0];
               ovf_d       = ovf_of(pre_prod);
            end
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_valid_q  <= 1'b0;
         dout_q       <= '0;
         ovf_q        <= 1'b0;
         acc_q        <= '0;
         acc_ovf_q    <= 1'b0;
         first_flag_q <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         dout_q       <= dout_d;
         ovf_q        <= ovf_d;
         acc_q        <= acc_d;
         acc_ovf_q    <= acc_ovf_d;
         first_flag_q <= first_flag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign dout_ovf  = ovf_q;

endmodule

// File: tb/tb_srcnn_mul_pipe_acc.sv
// Scoreboard bench for srcnn_mul_pipe_acc: five parameterisations share one stimulus port,
// one instance is selected at a time and checked against a reference model.
module tb_srcnn_mul_pipe_acc;

   localparam int W0  [5] = '{14, 8, 14, 14, 14};
   localparam int W1  [5] = '{12, 8, 12, 12, 12};
   localparam int DW  [5] = '{26, 8, 26, 20, 16};
   localparam int NS  [5] = '{3, 3, 3, 1, 8};
   localparam int S0  [5] = '{0, 1, 0, 1, 0};
   localparam int S1  [5] = '{0, 1, 0, 0, 1};
   localparam int ACC [5] = '{0, 0, 1, 0, 0};

   typedef struct {
      logic [63:0] d;
      logic        o;
      int          c;
      bit          l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [13:0] din0_s = '0;
   logic [11:0] din1_s = '0;
   logic [2:0]  sel = 3'd0;
   bit          lat_en = 1'b1;

   logic [4:0]  iv, ir, ov, ovf;
   logic [63:0] dout_a [5];
   logic [25:0] d0;
   logic [7:0]  d1;
   logic [25:0] d2;
   logic [19:0] d3;
   logic [15:0] d4;

   logic        ir_sel, ov_sel, ovf_sel;
   logic [63:0] dout_sel;

   int   cyc = 0;
   int   n_checks = 0, n_errors = 0;
   exp_t sb[$];

   logic [63:0] acc_m = '0;
   bit          aovf_m = 1'b0;
   bit          first_m = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign iv        = in_valid ? (5'd1 << sel) : 5'd0;
   assign dout_a[0] = 64'(d0);
   assign dout_a[1] = 64'(d1);
   assign dout_a[2] = 64'(d2);
   assign dout_a[3] = 64'(d3);
   assign dout_a[4] = 64'(d4);
   assign ir_sel    = ir[sel];
   assign ov_sel    = ov[sel];
   assign ovf_sel   = ovf[sel];
   assign dout_sel  = dout_a[sel];

   srcnn_mul_pipe_acc #(.DIN0_WIDTH(W0[0]), .DIN1_WIDTH(W1[0]), .DOUT_WIDTH(DW[0]),
      .NUM_STAGE(NS[0]), .SIGNED0(S0[0]), .SIGNED1(S1[0]), .ACC_EN(ACC[0])) u_dut0 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .din0(din0_s), .din1(din1_s), .in_first(in_first), .in_last(in_last),
      .out_valid(ov[0]), .out_ready(out_ready), .dout(d0), .dout_ovf(ovf[0]));

   srcnn_mul_pipe_acc #(.DIN0_WIDTH(W0[1]), .DIN1_WIDTH(W1[1]), .DOUT_WIDTH(DW[1]),
      .NUM_STAGE(NS[1]), .SIGNED0(S0[1]), .SIGNED1(S1[1]), .ACC_EN(ACC[1])) u_dut1 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .din0(din0_s[7:0]), .din1(din1_s[7:0]), .in_first(in_first), .in_last(in_last),
      .out_valid(ov[1]), .out_ready(out_ready), .dout(d1), .dout_ovf(ovf[1]));

   srcnn_mul_pipe_acc #(.DIN0_WIDTH(W0[2]), .DIN1_WIDTH(W1[2]), .DOUT_WIDTH(DW[2]),
      .NUM_STAGE(NS[2]), .SIGNED0(S0[2]), .SIGNED1(S1[2]), .ACC_EN(ACC[2])) u_dut2 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .din0(din0_s), .din1(din1_s), .in_first(in_first), .in_last(in_last),
      .out_valid(ov[2]), .out_ready(out_ready), .dout(d2), .dout_ovf(ovf[2]));

   srcnn_mul_pipe_acc #(.DIN0_WIDTH(W0[3]), .DIN1_WIDTH(W1[3]), .DOUT_WIDTH(DW[3]),
      .NUM_STAGE(NS[3]), .SIGNED0(S0[3]), .SIGNED1(S1[3]), .ACC_EN(ACC[3])) u_dut3 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
      .din0(din0_s), .din1(din1_s), .in_first(in_first), .in_last(in_last),
      .out_valid(ov[3]), .out_ready(out_ready), .dout(d3), .dout_ovf(ovf[3]));

   srcnn_mul_pipe_acc #(.DIN0_WIDTH(W0[4]), .DIN1_WIDTH(W1[4]), .DOUT_WIDTH(DW[4]),
      .NUM_STAGE(NS[4]), .SIGNED0(S0[4]), .SIGNED1(S1[4]), .ACC_EN(ACC[4])) u_dut4 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
      .din0(din0_s), .din1(din1_s), .in_first(in_first), .in_last(in_last),
      .out_valid(ov[4]), .out_ready(out_ready), .dout(d4), .dout_ovf(ovf[4]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] dmask(input int w);
      if (w >= 64) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] ext(input logic [63:0] v, input int w, input bit s);
      logic [63:0] m, r;
      m = dmask(w);
      r = v & m;
      if (s && (((v >> (w - 1)) & 64'd1) != 64'd0)) r = r | ~m;
      return r;
   endfunction

   function automatic bit ovf_ref(input logic [63:0] p, input int dw, input bit s);
      logic signed [63:0] t;
      if (dw >= 64) return 1'b0;
      if (!s) return (p >> dw) != 64'd0;
      t = $signed(p) >>> (dw - 1);
      return !((t == 0) || (t == -1));
   endfunction

   // Drive one beat, hold it until accepted, then push the model's expectation.
   task automatic send(input logic [63:0] a, input logic [63:0] b, input bit f, input bit l);
      logic [63:0] p, dm;
      bit          rs, isf, got;
      exp_t        e;
      @(posedge clk);
      #1;
      din0_s   = a[13:0];
      din1_s   = b[11:0];
      in_first = f;
      in_last  = l;
      in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ir_sel) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("accept_timeout", 64'(got), 64'd1);
         return;
      end
      rs  = (S0[sel] != 0) || (S1[sel] != 0);
      p   = ext(a, W0[sel], S0[sel] != 0) * ext(b, W1[sel], S1[sel] != 0);
      dm  = dmask(DW[sel]);
      e.c = cyc + NS[sel];
      e.l = lat_en;
      if (ACC[sel] != 0) begin
         isf     = f || first_m;
         first_m = 1'b0;
         if (isf) begin
            acc_m  = p;
            aovf_m = ovf_ref(p, DW[sel], rs);
         end else begin
            acc_m  = acc_m + p;
            aovf_m = aovf_m | ovf_ref(acc_m, DW[sel], rs);
         end
         if (!l) return;
         e.d = acc_m & dm;
         e.o = aovf_m;
      end else begin
         e.d = p & dm;
         e.o = ovf_ref(p, DW[sel], rs);
      end
      sb.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   // Output monitor: pops the scoreboard on every consumed beat.
   initial begin
      bit          prev_stall;
      logic [63:0] prev_dout;
      exp_t        e;
      prev_stall = 1'b0;
      prev_dout  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && ov_sel) check("hold", dout_sel, prev_dout);
            if (ov_sel && !out_ready) check("inrdy_stall", 64'(ir_sel), 64'd0);
            if (ov_sel && out_ready) begin
               if (sb.size() == 0) begin
                  check("spurious", 64'(ov_sel), 64'd0);
               end else begin
                  e = sb.pop_front();
                  check("dout", dout_sel, e.d);
                  check("ovf", 64'(ovf_sel), 64'(e.o));
                  if (e.l) check("latency", 64'(cyc), 64'(e.c));
               end
            end
            prev_stall = ov_sel && !out_ready;
            prev_dout  = dout_sel;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_inrdy", 64'(ir[0]), 64'd0);
      check("rst_ov", 64'(ov[0]), 64'd0);
      check("rst_dout", dout_a[0], 64'd0);
      check("rst_acc_ov", 64'(ov[2]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_inrdy", 64'(ir[0]), 64'd1);

      // Default plain multiply
      sel = 3'd0;
      send(64'd16383, 64'd4095, 1'b0, 1'b0);
      send(64'd0, 64'd0, 1'b0, 1'b0);
      idle();
      drain();

      // Signed 8x8 into 8 bits
      sel = 3'd1;
      send(64'h80, 64'h80, 1'b0, 1'b0);
      send(64'hFD, 64'h05, 1'b0, 1'b0);
      idle();
      drain();

      // Backpressure mid-stream
      sel    = 3'd0;
      lat_en = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) send(64'(i * 1500 + 7), 64'(i * 300 + 1), 1'b0, 1'b0);
            idle();
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      lat_en = 1'b1;

      // Accumulate
      sel = 3'd2;
      send(64'd2, 64'd3, 1'b1, 1'b0);
      send(64'd4, 64'd5, 1'b0, 1'b0);
      send(64'd1, 64'd1, 1'b0, 1'b1);
      send(64'd7, 64'd7, 1'b1, 1'b1);
      idle();
      drain();

      // Asynchronous reset with three beats in flight
      sel = 3'd0;
      send(64'd11, 64'd12, 1'b0, 1'b0);
      send(64'd13, 64'd14, 1'b0, 1'b0);
      send(64'd15, 64'd16, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("inflight_ov", 64'(ov[0]), 64'd1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_ov", 64'(ov[0]), 64'd0);
      check("midrst_inrdy", 64'(ir[0]), 64'd0);
      sb.delete();
      first_m = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel2_inrdy", 64'(ir[0]), 64'd1);
      repeat (8) @(negedge clk);
      send(64'd21, 64'd22, 1'b0, 1'b0);
      idle();
      drain();

      // Random sweep at the stage-count extremes
      for (int s = 3; s <= 4; s++) begin
         sel = 3'(s);
         for (int i = 0; i < 40; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle();
         end
         idle();
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
